// File: rtl/regfile_bypass_sb_pkg.sv
// Shared constants for the RV32I register file with bypass and busy scoreboard.
package regfile_bypass_sb_pkg;

   localparam int unsigned DEF_XLEN   = 32;
   localparam int unsigned DEF_NREG   = 32;
   localparam int unsigned DEF_AW     = 5;
   localparam int unsigned DEF_NUM_WP = 2;

   // Architectural zero register index
   localparam int unsigned REG_ZERO = 0;

   // Write-back port indices
   localparam int unsigned WP_ALU = 0;
   localparam int unsigned WP_LSU = 1;

endpackage : regfile_bypass_sb_pkg

// File: rtl/regfile_bypass_sb_if.sv
// Decode/write-back bus into the register file: read ports, issue and write-back ports.
interface regfile_bypass_sb_if
   import regfile_bypass_sb_pkg::*;
#(
   parameter int unsigned XLEN   = DEF_XLEN,
   parameter int unsigned AW     = DEF_AW,
   parameter int unsigned NUM_WP = DEF_NUM_WP
);

   logic [AW-1:0]          rs1_addr;
   logic [AW-1:0]          rs2_addr;
   logic [XLEN-1:0]        rs1_data;
   logic [XLEN-1:0]        rs2_data;
   logic                   rs1_busy;
   logic                   rs2_busy;
   logic                   issue_valid;
   logic [AW-1:0]          issue_rd;
   logic                   issue_waw;
   logic [NUM_WP-1:0]      wr_en;
   logic [NUM_WP*AW-1:0]   wr_addr;
   logic [NUM_WP*XLEN-1:0] wr_data;
   logic                   flush;

   // Pipeline side (decode + write-back)
   modport master (
      output rs1_addr, rs2_addr, issue_valid, issue_rd, wr_en, wr_addr, wr_data, flush,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, issue_waw
   );

   // Register file side
   modport slave (
      input  rs1_addr, rs2_addr, issue_valid, issue_rd, wr_en, wr_addr, wr_data, flush,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_waw
   );

endinterface : regfile_bypass_sb_if

// File: rtl/regfile_bypass_sb_scoreboard.sv
// Per-register busy bits tracking in-flight producers, with RAW/WAW hazard outputs.
module regfile_bypass_sb_scoreboard
   import regfile_bypass_sb_pkg::*;
#(
   parameter int unsigned NREG   = DEF_NREG,
   parameter int unsigned AW     = DEF_AW,
   parameter int unsigned NUM_WP = DEF_NUM_WP
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AW-1:0]        rs1_addr_i,
   input  logic [AW-1:0]        rs2_addr_i,
   input  logic                 issue_valid_i,
   input  logic [AW-1:0]        issue_rd_i,
   input  logic [NUM_WP-1:0]    wr_en_i,
   input  logic [NUM_WP*AW-1:0] wr_addr_i,
   input  logic                 flush_i,
   output logic                 rs1_busy_o,
   output logic                 rs2_busy_o,
   output logic                 issue_waw_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] wr_hit;

   // One-hot-ish map of registers being written back this cycle (x0 excluded)
   always_comb begin
      wr_hit = '0;
      for (int unsigned k = 0; k < NUM_WP; k++) begin
         if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] != AW'(REG_ZERO))) begin
            wr_hit[wr_addr_i[k*AW +: AW]] = 1'b1;
         end
      end
   end

   // Next busy state: write-back clears, flush clears all, otherwise issue sets (set beats clear)
   always_comb begin
      busy_d = busy_q & ~wr_hit;
      if (flush_i) begin
         busy_d = '0;
      end else if (issue_valid_i && (issue_rd_i != AW'(REG_ZERO))) begin
         busy_d[issue_rd_i] = 1'b1;
      end
   end

   // Busy bit register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // A same-cycle write-back releases the hazard since its data is bypassed
   assign rs1_busy_o  = busy_q[rs1_addr_i] & ~wr_hit[rs1_addr_i];
   assign rs2_busy_o  = busy_q[rs2_addr_i] & ~wr_hit[rs2_addr_i];
   assign issue_waw_o = issue_valid_i & busy_q[issue_rd_i] & ~wr_hit[issue_rd_i];

endmodule : regfile_bypass_sb_scoreboard

// File: rtl/regfile_bypass_sb.sv
// RV32I integer register file: storage, write-to-read bypass and busy scoreboard.
module regfile_bypass_sb
   import regfile_bypass_sb_pkg::*;
#(
   parameter int unsigned XLEN   = DEF_XLEN,
   parameter int unsigned NREG   = DEF_NREG,
   parameter int unsigned AW     = DEF_AW,
   parameter int unsigned NUM_WP = DEF_NUM_WP
) (
   input logic                clk,
   input logic                rst,
   regfile_bypass_sb_if.slave rf_bus
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];

   // Apply this cycle's writes in port order so the highest index wins; x0 never written
   always_comb begin
      regs_d = regs_q;
      for (int unsigned k = 0; k < NUM_WP; k++) begin
         if (rf_bus.wr_en[k] && (rf_bus.wr_addr[k*AW +: AW] != AW'(REG_ZERO))) begin
            regs_d[rf_bus.wr_addr[k*AW +: AW]] = rf_bus.wr_data[k*XLEN +: XLEN];
         end
      end
   end

   // Register storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads see the post-write view, which is exactly the bypassed value
   assign rf_bus.rs1_data = regs_d[rf_bus.rs1_addr];
   assign rf_bus.rs2_data = regs_d[rf_bus.rs2_addr];

   regfile_bypass_sb_scoreboard #(
      .NREG   (NREG),
      .AW     (AW),
      .NUM_WP (NUM_WP)
   ) u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .rs1_addr_i    (rf_bus.rs1_addr),
      .rs2_addr_i    (rf_bus.rs2_addr),
      .issue_valid_i (rf_bus.issue_valid),
      .issue_rd_i    (rf_bus.issue_rd),
      .wr_en_i       (rf_bus.wr_en),
      .wr_addr_i     (rf_bus.wr_addr),
      .flush_i       (rf_bus.flush),
      .rs1_busy_o    (rf_bus.rs1_busy),
      .rs2_busy_o    (rf_bus.rs2_busy),
      .issue_waw_o   (rf_bus.issue_waw)
   );

endmodule : regfile_bypass_sb

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: bypass, write priority, x0, scoreboard, flush, reset.
module tb_regfile_bypass_sb;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   regfile_bypass_sb_if rf_if ();

   regfile_bypass_sb dut (
      .clk    (clk),
      .rst    (rst),
      .rf_bus (rf_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      rf_if.rs1_addr    = 5'd0;
      rf_if.rs2_addr    = 5'd0;
      rf_if.issue_valid = 1'b0;
      rf_if.issue_rd    = 5'd0;
      rf_if.wr_en       = 2'b00;
      rf_if.wr_addr     = 10'd0;
      rf_if.wr_data     = 64'd0;
      rf_if.flush       = 1'b0;
   endtask

   // Drive port k write
   task automatic set_wr(input int k, input logic [4:0] a, input logic [31:0] d);
      rf_if.wr_en[k]          = 1'b1;
      rf_if.wr_addr[k*5 +: 5] = a;
      rf_if.wr_data[k*32 +: 32] = d;
   endtask

   // Advance across one rising edge; inputs change at the following negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drive_idle();
      rst = 1'b1;
      #1;
      check_val("rst_rs1_data", rf_if.rs1_data, 32'h0);
      check_val("rst_rs1_busy", 32'(rf_if.rs1_busy), 32'h0);
      check_val("rst_waw", 32'(rf_if.issue_waw), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single ALU write with same-cycle read bypass
      rf_if.rs1_addr = 5'd7;
      set_wr(0, 5'd7, 32'h1234_5678);
      #1;
      check_val("byp_rs1_data", rf_if.rs1_data, 32'h1234_5678);
      check_val("byp_rs1_busy", 32'(rf_if.rs1_busy), 32'h0);
      step();
      drive_idle();
      rf_if.rs1_addr = 5'd7;
      #1;
      check_val("stored_x7", rf_if.rs1_data, 32'h1234_5678);

      // Both ports hit x9: load port (index 1) wins
      drive_idle();
      rf_if.rs2_addr = 5'd9;
      set_wr(0, 5'd9, 32'h0000_AAAA);
      set_wr(1, 5'd9, 32'h0000_5555);
      #1;
      check_val("prio_byp_x9", rf_if.rs2_data, 32'h0000_5555);
      step();
      drive_idle();
      rf_if.rs2_addr = 5'd9;
      #1;
      check_val("prio_stored_x9", rf_if.rs2_data, 32'h0000_5555);

      // Write and issue to x0 are ignored
      drive_idle();
      rf_if.rs1_addr    = 5'd0;
      rf_if.issue_valid = 1'b1;
      rf_if.issue_rd    = 5'd0;
      set_wr(0, 5'd0, 32'hFFFF_FFFF);
      #1;
      check_val("x0_byp_data", rf_if.rs1_data, 32'h0);
      check_val("x0_waw", 32'(rf_if.issue_waw), 32'h0);
      step();
      drive_idle();
      rf_if.rs1_addr = 5'd0;
      #1;
      check_val("x0_stored", rf_if.rs1_data, 32'h0);
      check_val("x0_busy", 32'(rf_if.rs1_busy), 32'h0);

      // Issue x3: busy next cycle, WAW on re-issue
      drive_idle();
      rf_if.rs1_addr    = 5'd3;
      rf_if.issue_valid = 1'b1;
      rf_if.issue_rd    = 5'd3;
      #1;
      check_val("x3_busy_before", 32'(rf_if.rs1_busy), 32'h0);
      check_val("x3_waw_first", 32'(rf_if.issue_waw), 32'h0);
      step();
      rf_if.issue_valid = 1'b0;
      #1;
      check_val("x3_busy_after", 32'(rf_if.rs1_busy), 32'h1);
      rf_if.issue_valid = 1'b1;
      #1;
      check_val("x3_waw_reissue", 32'(rf_if.issue_waw), 32'h1);
      step();
      // Re-issue plus write-back to x3 same cycle: no hazard now, set wins
      set_wr(1, 5'd3, 32'hCAFE_F00D);
      #1;
      check_val("x3_wb_busy", 32'(rf_if.rs1_busy), 32'h0);
      check_val("x3_wb_data", rf_if.rs1_data, 32'hCAFE_F00D);
      check_val("x3_wb_waw", 32'(rf_if.issue_waw), 32'h0);
      step();
      drive_idle();
      rf_if.rs1_addr = 5'd3;
      #1;
      check_val("x3_still_busy", 32'(rf_if.rs1_busy), 32'h1);
      // Write-back alone releases x3
      set_wr(0, 5'd3, 32'h0000_0033);
      step();
      drive_idle();
      rf_if.rs1_addr = 5'd3;
      #1;
      check_val("x3_released", 32'(rf_if.rs1_busy), 32'h0);
      check_val("x3_final_data", rf_if.rs1_data, 32'h0000_0033);

      // Issue x4 with same-cycle write-back of x4: stays busy; also mark x8 busy
      drive_idle();
      rf_if.issue_valid = 1'b1;
      rf_if.issue_rd    = 5'd4;
      set_wr(0, 5'd4, 32'h0000_0044);
      step();
      drive_idle();
      rf_if.issue_valid = 1'b1;
      rf_if.issue_rd    = 5'd8;
      rf_if.rs2_addr    = 5'd4;
      #1;
      check_val("x4_set_wins", 32'(rf_if.rs2_busy), 32'h1);
      check_val("x4_data", rf_if.rs2_data, 32'h0000_0044);
      step();
      // Flush with issue x6 and a write to x10: all busy cleared, write lands
      drive_idle();
      rf_if.flush       = 1'b1;
      rf_if.issue_valid = 1'b1;
      rf_if.issue_rd    = 5'd6;
      set_wr(1, 5'd10, 32'h0000_0077);
      step();
      drive_idle();
      for (int a = 0; a < 32; a++) begin
         rf_if.rs1_addr = 5'(a);
         rf_if.rs2_addr = 5'(31 - a);
         #1;
         check_val($sformatf("flush_busy1_x%0d", a), 32'(rf_if.rs1_busy), 32'h0);
         check_val($sformatf("flush_busy2_x%0d", 31 - a), 32'(rf_if.rs2_busy), 32'h0);
      end
      rf_if.rs1_addr = 5'd10;
      #1;
      check_val("flush_write_x10", rf_if.rs1_data, 32'h0000_0077);

      // Mid-run reset after x5 written and issued: clears without a clock edge
      drive_idle();
      set_wr(0, 5'd5, 32'hDEAD_BEEF);
      rf_if.issue_valid = 1'b1;
      rf_if.issue_rd    = 5'd5;
      step();
      drive_idle();
      rf_if.rs1_addr = 5'd5;
      #1;
      check_val("x5_pre_rst_data", rf_if.rs1_data, 32'hDEAD_BEEF);
      check_val("x5_pre_rst_busy", 32'(rf_if.rs1_busy), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check_val("x5_rst_data", rf_if.rs1_data, 32'h0);
      for (int a = 0; a < 32; a++) begin
         rf_if.rs1_addr = 5'(a);
         #0.1;
         check_val($sformatf("rst_busy_x%0d", a), 32'(rf_if.rs1_busy), 32'h0);
         check_val($sformatf("rst_data_x%0d", a), rf_if.rs1_data, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      rf_if.rs1_addr = 5'd7;
      #1;
      check_val("x7_after_rst", rf_if.rs1_data, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_regfile_bypass_sb
